// File: rtl/avr_mem_pkg.sv
// -----------------------------------------------------------------------------
// avr_mem_pkg
// Shared constants and types for the AVR data-RAM subsystem.
//   AW_DEFAULT        default data-RAM address width
//   MAX_WAIT_DEFAULT  default secondary-wait limit for the starvation guard
//   owner_e           which master owns the read data returning this cycle
// -----------------------------------------------------------------------------
package avr_mem_pkg;

   localparam int unsigned AW_DEFAULT       = 16;
   localparam int unsigned MAX_WAIT_DEFAULT = 15;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_e;

endpackage : avr_mem_pkg

// File: rtl/starve_counter.sv
// -----------------------------------------------------------------------------
// starve_counter
// Counts consecutive cycles a secondary request has been waiting and raises
// o_force once the wait reaches MAX_WAIT, so the arbiter can steal one cycle
// from the core. Only instantiated when DRAM_ARBITER_STARVE_GUARD_EN is set.
// Ports:
//   clock    in   system clock
//   reset    in   synchronous, active-high reset
//   i_req    in   secondary request pending
//   i_ack    in   secondary request taken this cycle
//   o_force  out  wait limit reached; grant the secondary this cycle
// -----------------------------------------------------------------------------
module starve_counter
   import avr_mem_pkg::*;
#(
   parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
   input  logic clock,
   input  logic reset,
   input  logic i_req,
   input  logic i_ack,
   output logic o_force
);

   localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

   logic [7:0] r_wait;

   // NOTE: reset is sampled on the clock edge (synchronous), so it lives
   // inside the edge-triggered block rather than in the sensitivity list.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wait <= '0;
      end else if (i_ack || !i_req) begin
         r_wait <= '0;
      end else if (r_wait != 8'hFF) begin
         r_wait <= r_wait + 8'd1;
      end
   end

   assign o_force = (r_wait >= WAIT_LIMIT);

endmodule : starve_counter

// File: rtl/dram_arbiter.sv
// -----------------------------------------------------------------------------
// dram_arbiter
// Shares the single-port data RAM (1-cycle registered read) between the AVR
// core (fixed priority) and a secondary master (req/ack handshake) that is
// served in cycles the core leaves free.
// Build option:
//   DRAM_ARBITER_STARVE_GUARD_EN  when defined, a secondary request that has
//   waited MAX_WAIT cycles is granted by stalling the core for one cycle.
//   When undefined the secondary may starve and cpu_stall is constant 0.
// Ports:
//   clock, reset                        clock, synchronous active-high reset
//   cpu_req/address/wren/data_o         core access request
//   cpu_data_i, cpu_stall               read data / access not taken
//   dma_req/address/wren/wdata          secondary access request
//   dma_ack, dma_rdata, dma_rvalid      request taken / read data / valid
//   mem_address/data_o/wren, mem_data_i RAM port
// -----------------------------------------------------------------------------
module dram_arbiter
   import avr_mem_pkg::*;
#(
   parameter int unsigned AW       = AW_DEFAULT,
   parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic [AW-1:0] cpu_address,
   input  logic          cpu_wren,
   input  logic [7:0]    cpu_data_o,
   output logic [7:0]    cpu_data_i,
   output logic          cpu_stall,
   input  logic          dma_req,
   input  logic [AW-1:0] dma_address,
   input  logic          dma_wren,
   input  logic [7:0]    dma_wdata,
   output logic          dma_ack,
   output logic [7:0]    dma_rdata,
   output logic          dma_rvalid,
   output logic [AW-1:0] mem_address,
   output logic [7:0]    mem_data_o,
   output logic          mem_wren,
   input  logic [7:0]    mem_data_i
);

   if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
      $error("dram_arbiter: MAX_WAIT must be in 1..255");
   end

   logic   w_force;
   logic   w_gnt_dma;
   logic   w_gnt_cpu;
   logic   w_wren;
   owner_e r_owner;

`ifdef DRAM_ARBITER_STARVE_GUARD_EN
   starve_counter #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve_counter (
      .clock   (clock),
      .reset   (reset),
      .i_req   (dma_req),
      .i_ack   (dma_ack),
      .o_force (w_force)
   );

   assign cpu_stall = cpu_req & w_gnt_dma & ~reset;
`else
   assign w_force   = 1'b0;
   assign cpu_stall = 1'b0;
`endif

   // Core has priority unless the starvation guard forces a secondary slot.
   assign w_gnt_dma = dma_req & (~cpu_req | w_force);
   assign w_gnt_cpu = cpu_req & ~w_gnt_dma;
   assign dma_ack   = w_gnt_dma & ~reset;

   // NOTE: every signal written here gets a default first, so no path through
   // the block leaves one unassigned and no latch is inferred.
   always_comb begin
      mem_address = cpu_address;
      mem_data_o  = cpu_data_o;
      w_wren      = w_gnt_cpu & cpu_wren;
      if (w_gnt_dma) begin
         mem_address = dma_address;
         mem_data_o  = dma_wdata;
         w_wren      = dma_wren;
      end
   end

   assign mem_wren = w_wren & ~reset;

   // The owner of the next cycle's RAM read data is exactly the "secondary
   // read was granted last cycle" condition, so one register serves as both
   // the owner flag and the dma_rvalid state.
   // NOTE: state registers use non-blocking assignment so every flop samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_owner <= OWN_CPU;
      end else begin
         r_owner <= (w_gnt_dma && !dma_wren) ? OWN_DMA : OWN_CPU;
      end
   end

   // Masking with reset drops the read data of a grant made just before
   // reset rose.
   assign dma_rvalid = (r_owner == OWN_DMA) & ~reset;

   // RAM read data is routed to both masters; each knows when it is its own.
   assign dma_rdata  = mem_data_i;
   assign cpu_data_i = mem_data_i;

endmodule : dram_arbiter

// File: tb/tb_dram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dram_arbiter
// Self-checking bench for dram_arbiter. A behavioural RAM sits on the mem_*
// port; a separate reference model (shadow memory, pending-read flags and a
// wait count) predicts every handshake output and all returned data.
// Works with or without DRAM_ARBITER_STARVE_GUARD_EN defined.
// -----------------------------------------------------------------------------
module tb_dram_arbiter;

   localparam int AW       = 16;
   localparam int MAX_WAIT = 15;
`ifdef DRAM_ARBITER_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic          cpu_req, cpu_wren;
   logic [AW-1:0] cpu_address;
   logic [7:0]    cpu_data_o, cpu_data_i;
   logic          cpu_stall;
   logic          dma_req, dma_wren;
   logic [AW-1:0] dma_address;
   logic [7:0]    dma_wdata, dma_rdata;
   logic          dma_ack, dma_rvalid;
   logic [AW-1:0] mem_address;
   logic [7:0]    mem_data_o, mem_data_i;
   logic          mem_wren;

   always #5 clock = ~clock;

   dram_arbiter #(.AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
      .clock       (clock),
      .reset       (reset),
      .cpu_req     (cpu_req),
      .cpu_address (cpu_address),
      .cpu_wren    (cpu_wren),
      .cpu_data_o  (cpu_data_o),
      .cpu_data_i  (cpu_data_i),
      .cpu_stall   (cpu_stall),
      .dma_req     (dma_req),
      .dma_address (dma_address),
      .dma_wren    (dma_wren),
      .dma_wdata   (dma_wdata),
      .dma_ack     (dma_ack),
      .dma_rdata   (dma_rdata),
      .dma_rvalid  (dma_rvalid),
      .mem_address (mem_address),
      .mem_data_o  (mem_data_o),
      .mem_wren    (mem_wren),
      .mem_data_i  (mem_data_i)
   );

   // Behavioural single-port RAM with registered read.
   logic [7:0] ram [0:65535];
   always @(posedge clock) begin
      if (mem_wren) ram[mem_address] <= mem_data_o;
      mem_data_i <= ram[mem_address];
   end

   // Secondary master must hold its request fields until acked.
   assert property (@(posedge clock) disable iff (reset)
      (dma_req && !dma_ack) |=> (!dma_req || $stable({dma_address, dma_wren, dma_wdata})))
      else $error("FAIL protocol_hold dma request fields changed before ack");

   // ---------------- checking ----------------
   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] m_mem [0:65535];
   bit         m_dma_pend, m_cpu_pend;
   logic [7:0] m_dma_data, m_cpu_data;
   int         m_wait;
   bit         e_dma_gnt;
   int         n_ack, n_stall, n_wren, n_rvalid;
   bit         last_ack, last_stall, last_rvalid;

   function automatic logic [7:0] init_byte(input int a);
      return 8'(a) ^ 8'(a >> 8) ^ 8'hA5;
   endfunction

   // One clock cycle: inputs are already driven. Outputs are checked at the
   // falling edge, then the model advances with the rising edge.
   task automatic step();
      bit force_now, cpu_gets, exp_rv;
      @(negedge clock);
      force_now = GUARD && (m_wait >= MAX_WAIT);
      e_dma_gnt = !reset && dma_req && (!cpu_req || force_now);
      cpu_gets  = !reset && cpu_req && !e_dma_gnt;
      exp_rv    = m_dma_pend && !reset;
      check("dma_ack", dma_ack, e_dma_gnt);
      check("cpu_stall", cpu_stall, !reset && cpu_req && e_dma_gnt);
      check("mem_wren", mem_wren, e_dma_gnt ? dma_wren : (cpu_gets && cpu_wren));
      if (e_dma_gnt) begin
         check("mem_address_dma", mem_address, dma_address);
         if (dma_wren) check("mem_data_o_dma", mem_data_o, dma_wdata);
      end else if (cpu_gets) begin
         check("mem_address_cpu", mem_address, cpu_address);
         if (cpu_wren) check("mem_data_o_cpu", mem_data_o, cpu_data_o);
      end
      check("dma_rvalid", dma_rvalid, exp_rv);
      if (exp_rv) check("dma_rdata", dma_rdata, m_dma_data);
      if (m_cpu_pend) check("cpu_data_i", cpu_data_i, m_cpu_data);
      last_ack    = dma_ack;
      last_stall  = cpu_stall;
      last_rvalid = dma_rvalid;
      n_ack    += int'(dma_ack);
      n_stall  += int'(cpu_stall);
      n_wren   += int'(mem_wren);
      n_rvalid += int'(dma_rvalid);
      @(posedge clock);
      m_dma_pend = 1'b0;
      m_cpu_pend = 1'b0;
      if (e_dma_gnt) begin
         if (dma_wren) m_mem[dma_address] = dma_wdata;
         else begin
            m_dma_pend = 1'b1;
            m_dma_data = m_mem[dma_address];
         end
      end else if (cpu_gets) begin
         if (cpu_wren) m_mem[cpu_address] = cpu_data_o;
         else begin
            m_cpu_pend = 1'b1;
            m_cpu_data = m_mem[cpu_address];
         end
      end
      if (reset || !dma_req || e_dma_gnt) m_wait = 0;
      else if (m_wait < 255) m_wait++;
      #1;
   endtask

   task automatic idle_inputs();
      cpu_req = 1'b0; cpu_wren = 1'b0; cpu_address = '0; cpu_data_o = '0;
      dma_req = 1'b0; dma_wren = 1'b0; dma_address = '0; dma_wdata = '0;
   endtask

   initial begin
      int base_ack, base_stall, base_wren, base_rv, first_ack;

      for (int a = 0; a < 65536; a++) begin
         ram[a]   = init_byte(a);
         m_mem[a] = init_byte(a);
      end
      ram[16'h0200]   = 8'hC3;
      m_mem[16'h0200] = 8'hC3;
      m_dma_pend = 1'b0; m_cpu_pend = 1'b0; m_wait = 0;
      n_ack = 0; n_stall = 0; n_wren = 0; n_rvalid = 0;

      // Reset state, with a core write attempted during reset.
      idle_inputs();
      reset = 1'b1;
      repeat (2) step();
      cpu_req = 1'b1; cpu_wren = 1'b1; cpu_address = 16'h0005; cpu_data_o = 8'hFF;
      step();
      check("reset_no_write", ram[16'h0005], init_byte(16'h0005));
      idle_inputs();
      reset = 1'b0;
      step();

      // 1. Core-only write then read of 0x0100.
      base_wren = n_wren; base_stall = n_stall;
      cpu_req = 1'b1; cpu_wren = 1'b1; cpu_address = 16'h0100; cpu_data_o = 8'h5A;
      step();
      cpu_wren = 1'b0;
      step();
      check("t1_read_data", cpu_data_i, 8'h5A);
      cpu_req = 1'b0;
      step();
      check("t1_wren_pulses", n_wren - base_wren, 1);
      check("t1_no_stall", n_stall - base_stall, 0);

      // 2. Secondary-only reads.
      dma_req = 1'b1; dma_wren = 1'b0; dma_address = 16'h0200;
      step();
      check("t2_ack", last_ack, 1'b1);
      check("t2_rvalid", dma_rvalid, 1'b1);
      check("t2_rdata", dma_rdata, 8'hC3);
      base_rv = n_rvalid;
      for (int i = 0; i < 4; i++) begin
         dma_address = 16'(16'h0200 + i);
         step();
      end
      dma_req = 1'b0;
      step();
      check("t2_rvalid_run", n_rvalid - base_rv, 5);
      step();
      check("t2_rvalid_end", last_rvalid, 1'b0);

      // 3. Same-cycle write conflict: core wins, secondary retries.
      base_ack = n_ack;
      cpu_req = 1'b1; cpu_wren = 1'b1; cpu_address = 16'h0300; cpu_data_o = 8'h11;
      dma_req = 1'b1; dma_wren = 1'b1; dma_address = 16'h0300; dma_wdata = 8'h22;
      step();
      check("t3_ram_core", ram[16'h0300], 8'h11);
      check("t3_no_ack", n_ack - base_ack, 0);
      cpu_req = 1'b0; cpu_wren = 1'b0;
      step();
      check("t3_late_ack", last_ack, 1'b1);
      check("t3_ram_dma", ram[16'h0300], 8'h22);
      idle_inputs();
      step();

      // 4/5. Continuous core traffic with a held secondary read.
      base_ack = n_ack; base_stall = n_stall;
      cpu_req = 1'b1; cpu_address = 16'h0010;
      dma_req = 1'b1; dma_wren = 1'b0; dma_address = 16'h0020;
`ifdef DRAM_ARBITER_STARVE_GUARD_EN
      first_ack = -1;
      for (int i = 0; i < 40 && first_ack < 0; i++) begin
         step();
         if (last_ack) begin
            first_ack = i;
            check("t4_stall_at_grant", last_stall, 1'b1);
         end
      end
      check("t4_ack_cycle", first_ack, MAX_WAIT);
      dma_req = 1'b0;
      step();
      check("t4_core_proceeds", last_stall, 1'b0);
      check("t4_single_stall", n_stall - base_stall, 1);
`else
      first_ack = 0;
      repeat (300) step();
      check("t5_no_ack", n_ack - base_ack, first_ack);
      check("t5_no_stall", n_stall - base_stall, 0);
      cpu_req = 1'b0;
      step();
      check("t5_ack_when_idle", last_ack, 1'b1);
      dma_req = 1'b0;
`endif
      idle_inputs();
      step();

      // 6. Reset right after a secondary read ack.
      dma_req = 1'b1; dma_address = 16'h0200;
      step();
      check("t6_ack_N", last_ack, 1'b1);
      idle_inputs();
      reset = 1'b1;
      cpu_req = 1'b1; cpu_wren = 1'b1; cpu_address = 16'h0100; cpu_data_o = 8'hEE;
      step();
      check("t6_rvalid_N1", last_rvalid, 1'b0);
      step();
      check("t6_no_write", ram[16'h0100], 8'h5A);
      idle_inputs();
      reset = 1'b0;
      repeat (2) step();

      // Randomized traffic over a small address window to force collisions.
      for (int i = 0; i < 3000; i++) begin
         reset       = ($urandom_range(0, 99) == 0);
         cpu_req     = $urandom_range(0, 1) == 1;
         cpu_wren    = $urandom_range(0, 1) == 1;
         cpu_address = 16'($urandom_range(0, 15));
         cpu_data_o  = 8'($urandom);
         if (!(dma_req && !last_ack)) begin
            dma_req     = $urandom_range(0, 2) != 0;
            dma_wren    = $urandom_range(0, 1) == 1;
            dma_address = 16'($urandom_range(0, 15));
            dma_wdata   = 8'($urandom);
         end
         step();
      end
      reset = 1'b0;
      idle_inputs();
      step();
      for (int a = 0; a < 16; a++) check("final_ram", ram[a], m_mem[a]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_dram_arbiter

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares the single-port synchronous data RAM (`memdata`, 1-cycle read latency) between the AVR core and a secondary bus master (DMA or video fetch).
- The core has fixed priority. The secondary master uses a req/ack handshake and is served in cycles the core leaves free.
- Optionally, a starvation guard forces one secondary grant after a bounded wait by stalling the core.
- Sits between the core's `address`/`data_o`/`wren`/`data_i` pins and the RAM controller.

Parameters:
- AW, 16, address width of data RAM
- MAX_WAIT, 15, secondary-wait cycles before forced grant (only used with STARVE_GUARD_EN); legal range 1..255

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  core accesses RAM this cycle
- cpu_address  in  AW  core address
- cpu_wren  in  1  core write enable
- cpu_data_o  in  8  core write data
- cpu_data_i  out  8  read data to core
- cpu_stall  out  1  core access not taken this cycle; core holds request
- dma_req  in  1  secondary request; held until acked
- dma_address  in  AW  secondary address
- dma_wren  in  1  secondary write enable
- dma_wdata  in  8  secondary write data
- dma_ack  out  1  secondary request taken this cycle
- dma_rdata  out  8  secondary read data
- dma_rvalid  out  1  dma_rdata valid
- mem_address  out  AW  RAM address
- mem_data_o  out  8  RAM write data
- mem_wren  out  1  RAM write enable
- mem_data_i  in  8  RAM read data, registered by RAM one cycle after address

Behaviour:
- Grant is combinational from the current cycle's requests:
  - gnt_dma = dma_req & (~cpu_req | force).
  - gnt_cpu = cpu_req & ~gnt_dma.
  - force is 0 unless STARVE_GUARD_EN.
- RAM port mux:
  - gnt_dma: mem_* driven from dma_*.
  - Otherwise: mem_* driven from cpu_*. mem_wren = cpu_wren & cpu_req.
  - mem_wren = 0 whenever reset = 1.
- dma_ack = gnt_dma & ~reset.
- cpu_stall = cpu_req & gnt_dma.
- Read routing:
  - owner register: 1 when the previous cycle was a secondary read grant, else 0.
  - dma_rvalid register: set the cycle after gnt_dma & ~dma_wren, cleared otherwise.
  - dma_rdata = mem_data_i (passthrough, valid when dma_rvalid = 1).
  - cpu_data_i = mem_data_i always (core timing unchanged). Core ignores it in the cycle after a stall.
- Latency:
  - Secondary read: ack at cycle N, dma_rvalid and data at N+1.
  - Write commits at the edge ending the ack cycle.
- Back-to-back secondary reads: one per cycle while the core is idle; rvalid asserted continuously.
- Simultaneous core and secondary write to the same address: the core wins (no force). The secondary is not acked and retries next cycle.
- Reset (synchronous):
  - owner = 0, dma_rvalid = 0, wait counter = 0.
  - Outputs during reset: dma_ack = 0, cpu_stall = 0, mem_wren = 0.
  - A read acked in the cycle before reset asserts produces no rvalid.
- Secondary protocol violations (changing dma_address/dma_wren/dma_wdata while dma_req = 1 and dma_ack = 0) are undefined. Verification flags them with an assertion.

Optional Feature:
- Macro: DRAM_ARBITER_STARVE_GUARD_EN
- Defined:
  - 8-bit wait counter. It increments each cycle dma_req & ~dma_ack, saturating at 255, and clears on dma_ack or ~dma_req.
  - force = (wait >= MAX_WAIT). The secondary gets exactly that cycle, cpu_stall = 1, then the counter clears.
- Undefined:
  - No counter; force = 0; cpu_stall is constant 0.
  - The secondary can starve indefinitely under a continuous cpu_req.

Decomposition:
- Shared package `avr_mem_pkg`:
  - default address width constant (16).
  - owner encoding constants OWN_CPU = 0, OWN_DMA = 1.
  - default MAX_WAIT.
- One natural sub-module: `starve_counter` (saturating wait counter plus compare), instantiated only under the macro.
- Grant and mux logic stays inline.

Test Plan:
1. Core-only traffic: cpu_req = 1, write 0x5A to 0x0100, then read 0x0100 → mem_wren pulses once; cpu_data_i = 0x5A one cycle after the read address; cpu_stall stays 0.
2. Secondary-only traffic: dma_req read 0x0200 (preloaded 0xC3) → dma_ack in the same cycle; dma_rvalid = 1, dma_rdata = 0xC3 next cycle; 4 consecutive reads give 4 contiguous rvalid cycles.
3. Conflict: core and secondary both write 0x0300 (0x11 and 0x22) in the same cycle with the guard off → RAM holds 0x11 after that cycle; dma_ack = 0; the secondary write lands the next cycle when the core is idle, leaving 0x22.
4. Starvation, macro on, MAX_WAIT = 15: continuous cpu_req, dma_req read held from cycle 0 → dma_ack and cpu_stall both at cycle 15; counter returns to 0; core proceeds at cycle 16.
5. Starvation, macro off: same stimulus for 300 cycles → dma_ack never asserts; cpu_stall never asserts.
6. Reset mid-operation: dma read acked at cycle N, reset = 1 at cycle N+1 → dma_rvalid = 0 at N+1; mem_wren = 0 throughout reset even with cpu_wren = 1; all outputs idle after release until new requests arrive.
